// File: rtl/if_prefetch_stage_pkg.sv
// Shared fetch/decode bus widths, SRAM size encodings and bus layouts.
// Imported by the IF prefetch stage and reusable by the ID/EX stages.
package if_prefetch_stage_pkg;

  localparam int WIDTH_BR_BUS       = 34;
  localparam int WIDTH_FS_TO_DS_BUS = 64;

  localparam logic [1:0] SRAM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'b01;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_prefetch_stage_sync_fifo.sv
// Small synchronous FIFO with flush; head entry is read combinationally
// from the register array and forced to zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  // Flush dominates both push and pop in the same cycle.
  assign w_do_push = i_push && !i_flush && !o_full;
  assign w_do_pop  = i_pop && !i_flush && !o_empty;

  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with several fetches in flight and an instruction
// queue feeding decode; redirects flush the queue and squash stale returns.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int          IQ_DEPTH  = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h1C000000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ds_allow_in,
  input  logic [WIDTH_BR_BUS-1:0]       br_bus,
  output logic                          fs_to_ds_valid,
  output logic [WIDTH_FS_TO_DS_BUS-1:0] fs_to_ds_bus,
  output logic                          inst_sram_req,
  output logic                          inst_sram_wr,
  output logic [1:0]                    inst_sram_size,
  output logic [3:0]                    inst_sram_wstrb,
  output logic [31:0]                   inst_sram_addr,
  output logic [31:0]                   inst_sram_wdata,
  input  logic                          inst_sram_addr_ok,
  input  logic                          inst_sram_data_ok,
  input  logic [31:0]                   inst_sram_rdata
);

  localparam int OW   = $clog2(MAX_OUTST) + 1;
  localparam int IQCW = $clog2(IQ_DEPTH) + 1;

  br_bus_t     w_br;
  logic [31:0] r_fetch_pc;
  logic [OW-1:0] r_cancel_cnt;
  logic        r_req_hold;
  logic        r_redir_pending;
  logic [31:0] r_redir_target;

  logic        w_credit;
  logic        w_accept;
  logic        w_return;
  logic        w_drop;
  logic        w_iq_push;
  logic        w_iq_pop;
  logic [IQCW-1:0] w_iq_count;
  logic        w_iq_full;
  logic        w_iq_empty;
  fs_to_ds_t   w_iq_in;
  fs_to_ds_t   w_iq_head;
  logic [31:0] w_ret_pc;
  logic [OW-1:0] w_outst;
  logic        w_pq_full;
  logic        w_pq_empty;

  logic [OW-1:0] w_outst_next;
  logic [OW-1:0] w_cancel_next;
  logic [31:0] w_fetch_pc_next;
  logic        w_redir_pending_next;
  logic [31:0] w_redir_target_next;

  assign w_br = br_bus;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SRAM_SIZE_WORD;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = r_fetch_pc;

  // In-flight requests already hold an IQ slot, so the queue can never overflow.
  assign w_credit = resetn && !w_br.br_stall && !w_pq_full
                 && ((32'(w_outst) + 32'(w_iq_count)) < 32'(IQ_DEPTH));

  assign inst_sram_req = r_req_hold || w_credit;
  assign w_accept      = inst_sram_req && inst_sram_addr_ok;
  assign w_return      = inst_sram_data_ok && !w_pq_empty;

  assign w_drop    = w_br.br_taken || (r_cancel_cnt != '0);
  assign w_iq_push = w_return && !w_drop && !w_iq_full;
  assign w_iq_pop  = ds_allow_in && !w_iq_empty && !w_br.br_taken;
  assign w_iq_in   = '{inst: inst_sram_rdata, pc: w_ret_pc};

  assign fs_to_ds_valid = !w_iq_empty;
  assign fs_to_ds_bus   = w_iq_head;

  sync_fifo #(
    .WIDTH (WIDTH_FS_TO_DS_BUS),
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_iq_push),
    .i_push_data (w_iq_in),
    .i_pop       (w_iq_pop),
    .i_flush     (w_br.br_taken),
    .o_pop_data  (w_iq_head),
    .o_count     (w_iq_count),
    .o_full      (w_iq_full),
    .o_empty     (w_iq_empty)
  );

  // PC queue occupancy is the outstanding-request count.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTST)
  ) u_pcq (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_accept),
    .i_push_data (r_fetch_pc),
    .i_pop       (w_return),
    .i_flush     (1'b0),
    .o_pop_data  (w_ret_pc),
    .o_count     (w_outst),
    .o_full      (w_pq_full),
    .o_empty     (w_pq_empty)
  );

  always_comb begin
    w_outst_next = w_outst;
    case ({w_accept, w_return})
      2'b10:   w_outst_next = w_outst + OW'(1);
      2'b01:   w_outst_next = w_outst - OW'(1);
      default: ;
    endcase

    w_cancel_next = r_cancel_cnt;
    if (w_br.br_taken) begin
      w_cancel_next = w_outst_next;
    end else begin
      if (w_return && (r_cancel_cnt != '0)) begin
        w_cancel_next = w_cancel_next - OW'(1);
      end
      // The request held across a redirect fetched from the old stream.
      if (w_accept && r_redir_pending) begin
        w_cancel_next = w_cancel_next + OW'(1);
      end
    end
  end

  always_comb begin
    w_fetch_pc_next      = r_fetch_pc;
    w_redir_pending_next = r_redir_pending;
    w_redir_target_next  = r_redir_target;
    if (w_accept) begin
      if (w_br.br_taken) begin
        w_fetch_pc_next = w_br.br_target;
      end else if (r_redir_pending) begin
        w_fetch_pc_next = r_redir_target;
      end else begin
        w_fetch_pc_next = next_seq_pc(r_fetch_pc);
      end
      w_redir_pending_next = 1'b0;
    end else if (w_br.br_taken) begin
      // A pending request must keep its address, so park the target.
      if (inst_sram_req) begin
        w_redir_pending_next = 1'b1;
        w_redir_target_next  = w_br.br_target;
      end else begin
        w_fetch_pc_next = w_br.br_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fetch_pc      <= RESET_PC;
      r_cancel_cnt    <= '0;
      r_req_hold      <= 1'b0;
      r_redir_pending <= 1'b0;
      r_redir_target  <= '0;
    end else begin
      r_fetch_pc      <= w_fetch_pc_next;
      r_cancel_cnt    <= w_cancel_next;
      r_req_hold      <= inst_sram_req && !inst_sram_addr_ok;
      r_redir_pending <= w_redir_pending_next;
      r_redir_target  <= w_redir_target_next;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomised bench for if_prefetch_stage: a queue-based model of requests,
// in-flight fetches and the instruction queue is compared every cycle.
module tb_if_prefetch_stage;
  import if_prefetch_stage_pkg::*;

  localparam int          IQ_DEPTH  = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h1C000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ds_allow_in = 1'b0;
  logic [33:0] br_bus = '0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .IQ_DEPTH  (IQ_DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allow_in       (ds_allow_in),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  typedef struct packed {
    logic        stale;
    logic [31:0] pc;
  } flight_t;

  // Reference model: in-flight fetches tagged stale, plus the decode queue.
  flight_t     m_flight[$];
  logic [63:0] m_iq[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_redir_target = '0;
  bit          m_hold = 1'b0;
  bit          m_redir = 1'b0;

  logic [31:0] sram_q[$];
  logic [31:0] delivered[$];
  logic [31:0] accepted[$];

  int n_cmp = 0;
  int n_fail = 0;

  bit          s_req;
  bit          s_valid;
  logic [31:0] s_addr;
  logic [63:0] s_bus;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic run_cycle(input bit rst_n, input bit allow, input bit stall, input bit taken,
                           input logic [31:0] tgt, input int p_aok, input int p_dok);
    bit          aok;
    bit          dok;
    bit          exp_req;
    bit          acc;
    flight_t     e;
    logic [38:0] c_exp;
    resetn      = rst_n;
    ds_allow_in = allow;
    br_bus      = {stall, taken, tgt};
    aok = ($urandom_range(99) < p_aok);
    dok = rst_n && (sram_q.size() > 0) && ($urandom_range(99) < p_dok);
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok;
    inst_sram_rdata   = dok ? mem_fn(sram_q[0]) : $urandom;
    #2;
    exp_req = m_hold || (rst_n && !stall && (m_flight.size() + m_iq.size() < IQ_DEPTH)
                         && (m_flight.size() < MAX_OUTST));
    s_req   = inst_sram_req;
    s_addr  = inst_sram_addr;
    s_valid = fs_to_ds_valid;
    s_bus   = fs_to_ds_bus;
    check("req", 64'(s_req), 64'(exp_req));
    if (exp_req) check("addr", 64'(s_addr), 64'(m_fetch_pc));
    check("valid", 64'(s_valid), 64'(m_iq.size() > 0));
    if (m_iq.size() > 0) check("bus", s_bus, m_iq[0]);
    c_exp = {1'b0, 2'b10, 4'b0000, 32'h0};
    check("const", 64'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}), 64'(c_exp));
    @(posedge clk);
    if (!rst_n) begin
      m_flight.delete();
      m_iq.delete();
      sram_q.delete();
      m_fetch_pc = RESET_PC;
      m_hold  = 1'b0;
      m_redir = 1'b0;
    end else begin
      acc = exp_req && aok;
      e = '{stale: 1'b1, pc: 32'h0};
      if (dok && m_flight.size() > 0) e = m_flight.pop_front();
      if (!taken && allow && m_iq.size() > 0) void'(m_iq.pop_front());
      if (dok && !taken && !e.stale) m_iq.push_back({mem_fn(e.pc), e.pc});
      if (taken) begin
        m_iq.delete();
        foreach (m_flight[i]) m_flight[i].stale = 1'b1;
      end
      if (acc) begin
        m_flight.push_back('{stale: (taken || m_redir), pc: m_fetch_pc});
        m_fetch_pc = taken ? tgt : (m_redir ? m_redir_target : m_fetch_pc + 32'd4);
        m_redir = 1'b0;
      end else if (taken) begin
        if (exp_req) begin
          m_redir = 1'b1;
          m_redir_target = tgt;
        end else begin
          m_fetch_pc = tgt;
        end
      end
      m_hold = exp_req && !aok;
      if (s_valid && allow && !taken) begin
        delivered.push_back(s_bus[31:0]);
        $display("deliver pc=%h inst=%h", s_bus[31:0], s_bus[63:32]);
      end
      if (dok) void'(sram_q.pop_front());
      if (s_req && aok) begin
        sram_q.push_back(s_addr);
        accepted.push_back(s_addr);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
    delivered.delete();
    accepted.delete();
  endtask

  task automatic full_speed(input int n);
    repeat (n) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
  endtask

  initial begin
    int bad;
    int stall_left;
    bit stall;
    bit taken;
    logic [31:0] tgt;
    @(negedge clk);

    // Reset, then free run with 1-cycle SRAM.
    do_reset();
    check("rst_valid", 64'(s_valid), 64'd0);
    check("rst_bus", s_bus, 64'd0);
    check("rst_req", 64'(s_req), 64'd0);
    full_speed(1);
    check("first_req", 64'(s_req), 64'd1);
    check("first_addr", 64'(s_addr), 64'h1C000000);
    full_speed(19);
    check("run_count", 64'(delivered.size()), 64'd18);
    check("run_pc0", 64'(delivered[0]), 64'h1C000000);
    check("run_pc1", 64'(delivered[1]), 64'h1C000004);
    bad = 0;
    foreach (delivered[i]) if (delivered[i] != RESET_PC + 32'(4 * i)) bad++;
    check("run_seq", 64'(bad), 64'd0);

    // Decode blocked: credit limits accepts to the queue depth.
    do_reset();
    repeat (10) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 100, 100);
    check("blk_accepts", 64'(accepted.size()), 64'd4);
    check("blk_req", 64'(s_req), 64'd0);
    check("blk_valid", 64'(s_valid), 64'd1);
    full_speed(8);
    check("blk_pc0", 64'(delivered[0]), 64'h1C000000);
    check("blk_pc1", 64'(delivered[1]), 64'h1C000004);
    check("blk_pc2", 64'(delivered[2]), 64'h1C000008);
    check("blk_pc3", 64'(delivered[3]), 64'h1C00000C);

    // Branch with two fetches in flight.
    do_reset();
    repeat (2) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 100, 0);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h1C000100, 100, 0);
    full_speed(10);
    check("br2_acc", 64'(accepted[2]), 64'h1C000100);
    check("br2_pc0", 64'(delivered[0]), 64'h1C000100);

    // Branch while a request waits for addr_ok.
    do_reset();
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h1C000200, 0, 0);
    repeat (2) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    check("hold_req", 64'(s_req), 64'd1);
    check("hold_addr", 64'(s_addr), 64'h1C000000);
    full_speed(10);
    check("hold_acc0", 64'(accepted[0]), 64'h1C000000);
    check("hold_acc1", 64'(accepted[1]), 64'h1C000200);
    check("hold_pc0", 64'(delivered[0]), 64'h1C000200);

    // Branch coinciding with data_ok and a pop.
    do_reset();
    full_speed(3);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h1C000300, 100, 100);
    check("flush_cnt", 64'(delivered.size()), 64'd1);
    full_speed(1);
    check("flush_valid", 64'(s_valid), 64'd0);
    full_speed(8);
    check("flush_pc1", 64'(delivered[1]), 64'h1C000300);

    // br_stall blocks new requests but not returns.
    do_reset();
    full_speed(3);
    repeat (5) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 100, 100);
    check("stall_acc", 64'(accepted.size()), 64'd3);
    full_speed(8);
    bad = 0;
    foreach (delivered[i]) if (delivered[i] != RESET_PC + 32'(4 * i)) bad++;
    check("stall_seq", 64'(bad), 64'd0);
    check("stall_cnt", 64'(delivered.size()), 64'd9);

    // Randomised traffic against the model.
    do_reset();
    stall_left = 0;
    for (int c = 0; c < 4000; c++) begin
      stall = 1'b0;
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else if ($urandom_range(39) == 0) begin
        stall_left = int'($urandom_range(6, 1));
      end
      taken = ($urandom_range(99) < 6);
      tgt = 32'h1C000000 | ($urandom & 32'h0000FFFC);
      if ($urandom_range(9) == 0) tgt = 32'hFFFFFFF4;
      if ($urandom_range(19) == 0) tgt[1:0] = 2'b01;
      run_cycle(!(c == 2000 || c == 2001), ($urandom_range(99) < 70), stall, taken, tgt, 60, 60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
